run_pattern_gen: RTL and testbench

- Decoder counterpart of the team's max-run-length priority encoder, which maps an 8-bit word Y to Z, the length of its longest run of 1s.
- This block goes the other way: it takes a requested run length and a start position, and builds the 8-bit word containing exactly that circular run of 1s.
- The word is built bit-serially, LSB first, over W cycles and presented with valid/ready handshakes.
- Used as a stimulus and pattern source feeding the encoder path.

---
 rtl/run_pattern_gen.sv | 164 ++++++++++++++++
 tb/tb_run_pattern_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_pattern_gen.sv
// Bit-serial circular run-pattern generator: builds a W-bit word holding one run of 1s.
// Optional RUN_PATTERN_SELF_CHECK_EN adds a run counter that re-measures the built word.
module run_pattern_gen #(
    parameter int W = 8,
    localparam int LW = $clog2(W + 1),
    localparam int PW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [LW-1:0] in_len,
    input  logic [PW-1:0] in_pos,
    input  logic          abort,
    output logic          ser_valid,
    output logic          ser_bit,
    output logic [PW-1:0] ser_idx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_y,
    output logic          out_err,
    output logic [LW-1:0] chk_run,
    output logic          chk_err
);

    typedef enum logic [1:0] {IDLE, BUILD, DONE} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q;
    logic [PW-1:0] pos_q;
    logic [PW-1:0] idx_q;
    logic          err_q;
    logic [W-1:0]  y_q;
    logic [PW-1:0] diff;
    logic          bit_c;
    logic          accept;
    logic          last;

    // Offset from the run start wraps naturally in PW bits because W is a power of 2.
    assign diff   = idx_q - pos_q;
    assign bit_c  = LW'(diff) < len_q;
    assign accept = (state_q == IDLE) && in_valid && !abort;
    assign last   = (idx_q == PW'(W - 1));

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        ser_idx   = '0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = BUILD;
            end
            BUILD: begin
                ser_valid = 1'b1;
                ser_bit   = bit_c;
                ser_idx   = idx_q;
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            pos_q <= '0;
            idx_q <= '0;
            err_q <= 1'b0;
            y_q   <= '0;
        end else if (abort) begin
            idx_q <= '0;
            err_q <= 1'b0;
            y_q   <= '0;
        end else if (accept) begin
            len_q <= (in_len > LW'(W)) ? LW'(W) : in_len;
            pos_q <= in_pos;
            err_q <= (in_len > LW'(W));
            idx_q <= '0;
            y_q   <= '0;
        end else if (state_q == BUILD) begin
            y_q[idx_q] <= bit_c;
            idx_q      <= idx_q + 1'b1;
        end
    end

    assign out_y   = y_q;
    assign out_err = err_q;

`ifdef RUN_PATTERN_SELF_CHECK_EN
    logic [LW-1:0] cur_q, max_q, lead_q, chk_run_q;
    logic          lead_open_q, chk_err_q;
    logic [LW-1:0] cur_n, max_n, lead_n, wrap_n, meas;
    logic          lead_open_n;

    // The leading run (from bit 0) is joined to the trailing run to measure wrap-around.
    always_comb begin
        cur_n       = bit_c ? cur_q + 1'b1 : '0;
        max_n       = (cur_n > max_q) ? cur_n : max_q;
        lead_open_n = lead_open_q && bit_c;
        lead_n      = lead_open_n ? lead_q + 1'b1 : lead_q;
        wrap_n      = lead_n + cur_n;
        meas        = max_n;
        if (lead_open_n)        meas = LW'(W);
        else if (wrap_n > max_n) meas = wrap_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q       <= '0;
            max_q       <= '0;
            lead_q      <= '0;
            lead_open_q <= 1'b0;
            chk_run_q   <= '0;
            chk_err_q   <= 1'b0;
        end else if (abort) begin
            cur_q       <= '0;
            max_q       <= '0;
            lead_q      <= '0;
            lead_open_q <= 1'b0;
            chk_run_q   <= '0;
            chk_err_q   <= 1'b0;
        end else if (accept) begin
            cur_q       <= '0;
            max_q       <= '0;
            lead_q      <= '0;
            lead_open_q <= 1'b1;
            chk_run_q   <= '0;
            chk_err_q   <= 1'b0;
        end else if (state_q == BUILD) begin
            cur_q       <= cur_n;
            max_q       <= max_n;
            lead_q      <= lead_n;
            lead_open_q <= lead_open_n;
            if (last) begin
                chk_run_q <= meas;
                chk_err_q <= (meas != len_q);
            end
        end
    end

    assign chk_run = chk_run_q;
    assign chk_err = chk_err_q;
`else
    assign chk_run = '0;
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_run_pattern_gen.sv
// Testbench for run_pattern_gen: directed cases plus randomized requests against a
// reference model that derives each pattern from the run length/position arithmetic.
module tb_run_pattern_gen;

    localparam int W  = 8;
    localparam int LW = $clog2(W + 1);
    localparam int PW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LW-1:0] in_len = '0;
    logic [PW-1:0] in_pos = '0;
    logic          abort = 1'b0;
    logic          ser_valid;
    logic          ser_bit;
    logic [PW-1:0] ser_idx;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_y;
    logic          out_err;
    logic [LW-1:0] chk_run;
    logic          chk_err;

    int checks = 0;
    int errors = 0;

    run_pattern_gen #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_len   (in_len),
        .in_pos   (in_pos),
        .abort    (abort),
        .ser_valid(ser_valid),
        .ser_bit  (ser_bit),
        .ser_idx  (ser_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y),
        .out_err  (out_err),
        .chk_run  (chk_run),
        .chk_err  (chk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    function automatic logic [W-1:0] model_pattern(input int len, input int pos);
        logic [W-1:0] p;
        int l;
        l = (len > W) ? W : len;
        for (int i = 0; i < W; i++) p[i] = (((i - pos + W) % W) < l);
        return p;
    endfunction

    // Longest circular run of 1s, found by scanning the word twice around.
    function automatic int model_run(input logic [W-1:0] y);
        int cur, best;
        cur = 0;
        best = 0;
        for (int k = 0; k < 2 * W; k++) begin
            cur = y[k % W] ? cur + 1 : 0;
            if (cur > best) best = cur;
        end
        return (best > W) ? W : best;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".in_ready"}, in_ready, 1);
        check({tag, ".ser_valid"}, ser_valid, 0);
        check({tag, ".ser_bit"}, ser_bit, 0);
        check({tag, ".ser_idx"}, ser_idx, 0);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".out_y"}, out_y, 0);
        check({tag, ".out_err"}, out_err, 0);
        check({tag, ".chk_run"}, chk_run, 0);
        check({tag, ".chk_err"}, chk_err, 0);
    endtask

    // Full request: accept, serial phase, optional backpressure with an ignored request, handshake.
    task automatic run_req(input int len, input int pos, input int hold);
        logic [W-1:0] exp_y;
        exp_y = model_pattern(len, pos);
        check("req.in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_len   = LW'(len);
        in_pos   = PW'(pos);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            check("build.ser_valid", ser_valid, 1);
            check("build.in_ready", in_ready, 0);
            check("build.ser_idx", ser_idx, i);
            check("build.ser_bit", ser_bit, exp_y[i]);
            check("build.out_valid", out_valid, 0);
            step();
        end
        check("done.out_valid", out_valid, 1);
        check("done.ser_valid", ser_valid, 0);
        check("done.out_y", out_y, exp_y);
        check("done.out_err", out_err, (len > W));
`ifdef RUN_PATTERN_SELF_CHECK_EN
        check("done.chk_run", chk_run, model_run(exp_y));
        check("done.chk_run_len", chk_run, (len > W) ? W : len);
        check("done.chk_err", chk_err, 0);
`else
        check("done.chk_run", chk_run, 0);
        check("done.chk_err", chk_err, 0);
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid = (h == 1);
            in_len   = LW'(1);
            in_pos   = PW'(3);
            step();
            check("hold.out_valid", out_valid, 1);
            check("hold.in_ready", in_ready, 0);
            check("hold.out_y", out_y, exp_y);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ack.out_valid", out_valid, 0);
        check("ack.in_ready", in_ready, 1);
        check("ack.ser_valid", ser_valid, 0);
        check("ack.out_y_kept", out_y, exp_y);
    endtask

    initial begin
        logic [W-1:0] lit;
        // Reset state
        #2;
        check_idle_reset("reset");
        step();
        rst_n = 1'b1;
        step();
        check_idle_reset("post_reset");

        // Directed cases, including the literal patterns named for them
        run_req(3, 6, 0);
        lit = 8'b1100_0001;
        check("lit.len3_pos6", out_y, lit);
        run_req(0, 2, 0);
        run_req(8, 5, 0);
        run_req(12, 0, 0);
        check("clamp.out_err_kept", out_err, 1);
        run_req(5, 6, 5);

        // abort at idx 4 during BUILD
        in_valid = 1'b1;
        in_len   = LW'(4);
        in_pos   = PW'(1);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("abort.pre_idx", ser_idx, 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort.in_ready", in_ready, 1);
        check("abort.out_y", out_y, 0);
        check("abort.out_valid", out_valid, 0);
        check("abort.ser_valid", ser_valid, 0);
        check("abort.out_err", out_err, 0);

        // Request offered together with abort is not taken
        abort    = 1'b1;
        in_valid = 1'b1;
        in_len   = LW'(3);
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_req.in_ready", in_ready, 1);
        check("abort_req.ser_valid", ser_valid, 0);

        run_req(2, 7, 0);
        lit = 8'b1000_0001;
        check("lit.len2_pos7", out_y, lit);

        // Randomized requests
        for (int n = 0; n < 24; n++) begin
            run_req(int'($urandom_range(0, 15)), int'($urandom_range(0, W - 1)),
                    int'($urandom_range(0, 3)));
        end

`ifdef RUN_PATTERN_SELF_CHECK_EN
        for (int l = 0; l <= W; l++)
            for (int p = 0; p < W; p++)
                run_req(l, p, 0);
`endif

        // Reset asserted mid-BUILD clears everything without a clock edge
        in_valid = 1'b1;
        in_len   = LW'(6);
        in_pos   = PW'(2);
        step();
        in_valid = 1'b0;
        repeat (3) step();
        check("midrst.pre_ser_valid", ser_valid, 1);
        rst_n = 1'b0;
        #1;
        check_idle_reset("midrst");
        step();
        rst_n = 1'b1;
        step();
        run_req(7, 3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
